// File: rtl/fp32_mac_ctrl.sv
// -----------------------------------------------------------------------------
// fp32_mac_ctrl
//
// Sequences one single-precision multiply-accumulate (A*B+C) per received
// frame: captures the three operands from the receiver, issues them to an
// external FP32 MAC, waits (bounded) for its result and hands the result to a
// transmitter. Frames that arrive while a previous one is still in flight are
// dropped and flagged; a MAC that never answers is flagged and abandoned.
//
// Parameters
//   MAC_TIMEOUT  cycles to wait for MAC_DONE_I after MAC_START_O (>= 1)
//   CNT_W        width of the delivered-frame counter
//
// Ports
//   CLK_I         in   1      sole clock, rising edge
//   RSTL_I        in   1      asynchronous active-low reset
//   RX_VALID_I    in   1      receiver level, low while a frame is received
//   RX_DATA_I     in   96     operands A=[31:0], B=[63:32], C=[95:64]
//   RX_READY_O    out  1      high only while idle
//   MAC_START_O   out  1      one-cycle operand-issue pulse
//   MAC_A_O/B/C   out  32     registered operands
//   MAC_DONE_I    in   1      one-cycle result-valid pulse
//   MAC_RESULT_I  in   32     MAC result
//   TX_START_O    out  1      one-cycle transmit request
//   TX_DATA_O     out  32     registered result
//   TX_BUSY_I     in   1      transmitter busy level
//   OVERRUN_O     out  1      sticky: a frame was dropped
//   TIMEOUT_O     out  1      sticky: the MAC failed to answer in time
//   FRAME_CNT_O   out  CNT_W  results handed to the transmitter (wrapping)
// -----------------------------------------------------------------------------
module fp32_mac_ctrl #(
  parameter int MAC_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             CLK_I,
  input  logic             RSTL_I,
  input  logic             RX_VALID_I,
  input  logic [95:0]      RX_DATA_I,
  output logic             RX_READY_O,
  output logic             MAC_START_O,
  output logic [31:0]      MAC_A_O,
  output logic [31:0]      MAC_B_O,
  output logic [31:0]      MAC_C_O,
  input  logic             MAC_DONE_I,
  input  logic [31:0]      MAC_RESULT_I,
  output logic             TX_START_O,
  output logic [31:0]      TX_DATA_O,
  input  logic             TX_BUSY_I,
  output logic             OVERRUN_O,
  output logic             TIMEOUT_O,
  output logic [CNT_W-1:0] FRAME_CNT_O
);

  // Wide enough to hold MAC_TIMEOUT itself; the counter only ever reaches
  // MAC_TIMEOUT-1, at which point the wait is abandoned.
  localparam int              TO_W    = $clog2(MAC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MAC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    MAC_WAIT = 3'd2,
    TX_REQ   = 3'd3,
    TX_WAIT  = 3'd4
  } state_t;

  state_t            state_reg,     state_next;
  logic              rx_prev_reg;
  logic              mac_start_reg, mac_start_next;
  logic              tx_start_reg,  tx_start_next;
  logic [31:0]       tx_data_reg,   tx_data_next;
  logic              overrun_reg,   overrun_next;
  logic              timeout_reg,   timeout_next;
  logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic [TO_W-1:0]   to_cnt_reg,    to_cnt_next;

  logic              frame_event;
  logic              load_ops;
  logic [31:0]       op_q [3];

  // A frame has just completed when the valid level rises. The history
  // register resets to 1 so a level already high out of reset is ignored.
  assign frame_event = RX_VALID_I & ~rx_prev_reg;

  // ---------------------------------------------------------------------------
  // Operand lanes: lane 0 = A, lane 1 = B, lane 2 = C. Loaded only from IDLE,
  // so a dropped frame can never disturb operands already issued.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [31:0] lane_reg;

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
      if (!RSTL_I) begin
        lane_reg <= '0;
      end else if (load_ops) begin
        lane_reg <= RX_DATA_I[gi*32 +: 32];
      end
    end

    assign op_q[gi] = lane_reg;
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_reg     <= IDLE;
      rx_prev_reg   <= 1'b1;
      mac_start_reg <= 1'b0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= '0;
      overrun_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      to_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      rx_prev_reg   <= RX_VALID_I;
      mac_start_reg <= mac_start_next;
      tx_start_reg  <= tx_start_next;
      tx_data_reg   <= tx_data_next;
      overrun_reg   <= overrun_next;
      timeout_reg   <= timeout_next;
      frame_cnt_reg <= frame_cnt_next;
      to_cnt_reg    <= to_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // The start pulses are registered: they appear the cycle after the state
  // that requests them, which gives the two-cycle frame->issue and
  // done->transmit latencies. Each is raised from a different state, so the
  // two pulses can never coincide.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    mac_start_next = 1'b0;
    tx_start_next  = 1'b0;
    tx_data_next   = tx_data_reg;
    overrun_next   = overrun_reg;
    timeout_next   = timeout_reg;
    frame_cnt_next = frame_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    load_ops       = 1'b0;

    // Any frame outside IDLE is dropped and remembered until reset.
    if (frame_event && (state_reg != IDLE)) begin
      overrun_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (frame_event) begin
          load_ops   = 1'b1;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        mac_start_next = 1'b1;
        to_cnt_next    = '0;
        state_next     = MAC_WAIT;
      end

      MAC_WAIT: begin
        if (MAC_DONE_I) begin
          tx_data_next = MAC_RESULT_I;
          state_next   = TX_REQ;
        end else if (to_cnt_reg == TO_LAST) begin
          // MAC_TIMEOUT cycles elapsed without a result: give up on this
          // frame, keep the previous TX data and go back for the next one.
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      TX_REQ: begin
        if (!TX_BUSY_I) begin
          tx_start_next  = 1'b1;
          frame_cnt_next = frame_cnt_reg + 1'b1;
          state_next     = TX_WAIT;
        end
      end

      TX_WAIT: begin
        // The TX_START pulse is visible during the first cycle here, so this
        // state always lasts at least one cycle before the busy test matters.
        if (!TX_BUSY_I) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign RX_READY_O  = (state_reg == IDLE);
  assign MAC_START_O = mac_start_reg;
  assign MAC_A_O     = op_q[0];
  assign MAC_B_O     = op_q[1];
  assign MAC_C_O     = op_q[2];
  assign TX_START_O  = tx_start_reg;
  assign TX_DATA_O   = tx_data_reg;
  assign OVERRUN_O   = overrun_reg;
  assign TIMEOUT_O   = timeout_reg;
  assign FRAME_CNT_O = frame_cnt_reg;

endmodule

// File: doc/fp32_mac_ctrl.md
FP32_MAC_CTRL -- requirements
Module: fp32_mac_ctrl

Parameters
REQ-001 SHALL provide MAC_TIMEOUT, default 1024, max cycles to wait for MAC_DONE_I after MAC_START_O.
REQ-002 SHALL provide CNT_W, default 16, width of the frame counter.

Interface
REQ-003 SHALL have CLK_I  in  1  sole clock, rising edge.
REQ-004 SHALL have RSTL_I  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have RX_VALID_I  in  1  receiver frame-valid level; low while a frame is being received, high otherwise.
REQ-006 SHALL have RX_DATA_I  in  96  operands: A=[31:0], B=[63:32], C=[95:64].
REQ-007 SHALL have RX_READY_O  out  1  high only in IDLE.
REQ-008 SHALL have MAC_START_O  out  1  one-cycle operand-issue pulse.
REQ-009 SHALL have MAC_A_O, MAC_B_O, MAC_C_O  out  32 each  registered operands, computing A*B+C.
REQ-010 SHALL have MAC_DONE_I  in  1  one-cycle result-valid pulse; MAC_RESULT_I  in  32  result.
REQ-011 SHALL have TX_START_O  out  1  one-cycle transmit request; TX_DATA_O  out  32  registered result.
REQ-012 SHALL have TX_BUSY_I  in  1  transmitter busy level.
REQ-013 SHALL have OVERRUN_O  out  1  sticky dropped-frame flag; TIMEOUT_O  out  1  sticky MAC-timeout flag.
REQ-014 SHALL have FRAME_CNT_O  out  CNT_W  count of results handed to TX, wraps modulo 2^CNT_W.

Function
REQ-015 SHALL implement states IDLE, ISSUE, MAC_WAIT, TX_REQ, TX_WAIT.
REQ-016 SHALL register RX_VALID_I each cycle and define frame event = RX_VALID_I high with previous sample low (rising edge); a level that stays high SHALL NOT trigger.
REQ-017 IDLE: on frame event, latch A/B/C into MAC_*_O and go to ISSUE next cycle.
REQ-018 ISSUE: assert MAC_START_O for exactly one cycle, clear the timeout counter, go to MAC_WAIT.
REQ-019 MAC_WAIT: on MAC_DONE_I, latch MAC_RESULT_I into TX_DATA_O and go to TX_REQ.
REQ-020 MAC_WAIT: the counter increments each cycle without MAC_DONE_I; upon reaching MAC_TIMEOUT it SHALL set TIMEOUT_O, leave TX_DATA_O unchanged, and return to IDLE without transmitting.
REQ-021 TX_REQ: wait while TX_BUSY_I high; when low, pulse TX_START_O one cycle, increment FRAME_CNT_O, go to TX_WAIT.
REQ-022 TX_WAIT: stay one cycle minimum, then return to IDLE when TX_BUSY_I is low.
REQ-023 A frame event in any state other than IDLE SHALL set OVERRUN_O and be dropped; the operands in use SHALL NOT change.
REQ-024 MAC_DONE_I outside MAC_WAIT SHALL be ignored.
REQ-025 Latency: frame event cycle N -> MAC_START_O at N+2; MAC_DONE_I at cycle M with TX idle -> TX_START_O at M+2.
REQ-026 MAC_START_O and TX_START_O SHALL never be high in the same cycle.
REQ-027 OVERRUN_O and TIMEOUT_O SHALL clear only on reset.
REQ-028 FRAME_CNT_O at all-ones SHALL wrap to 0 on the next TX_START_O.
REQ-029 Undefined state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-030 RSTL_I low SHALL force, asynchronously: state IDLE, all outputs 0 except RX_READY_O=1, and the RX_VALID_I history register=1, so the post-reset high level is not treated as a frame event.
REQ-031 Reset asserted mid-operation SHALL abort without emitting any further MAC_START_O or TX_START_O pulse.

Verification
REQ-032 Frame A=0x3F800000, B=0x40000000, C=0x40400000, model MAC returns 0x40A00000 after 5 cycles -> MAC_START_O at N+2, TX_DATA_O=0x40A00000, a single TX_START_O, FRAME_CNT_O=1.
REQ-033 Release reset with RX_VALID_I held high for 100 cycles -> no MAC_START_O, RX_READY_O=1.
REQ-034 MAC never responds, MAC_TIMEOUT=16 -> TIMEOUT_O=1 after 16 wait cycles, no TX_START_O, return to IDLE, next frame processed normally.
REQ-035 Second frame event arrives during MAC_WAIT -> OVERRUN_O=1, first result transmitted unaltered, only one TX_START_O.
REQ-036 TX_BUSY_I held high 50 cycles when the result arrives -> TX_START_O delayed until the cycle after TX_BUSY_I falls.
REQ-037 CNT_W=2, five frames processed -> FRAME_CNT_O sequence 1,2,3,0,1; reset pulse in MAC_WAIT -> all outputs at reset values, no pulses.
